// File: rtl/mss_ahb_master.sv
// Purpose : CPU-side request to AHB-Lite master for the MSS RAM; each request is
//           split into single-byte, non-pipelined transfers (1 for byte, 4 for word).
// Latency : req to ack = 3 cycles (byte) / 9 cycles (word) with a zero-wait slave.
// Backpr. : HREADY stretches the data phase up to TIMEOUT cycles; req is ignored while busy.
// Ports   : clk/rst (sync, active-high); CPU side req/we/size/addr/wdata -> rdata/ack/err/busy;
//           AHB-Lite master HADDR/HSIZE/HTRANS/HWRITE/HWDATA/HMASTLOCK, slave HRDATA/HREADY/HRESP.
module mss_ahb_master #(
    parameter logic [15:0] BASE_HI = 16'h2000,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [14:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic        HMASTLOCK,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_we;
    logic        r_size;
    logic [12:0] r_word_base;   // addr[14:2] of a word request
    logic [31:0] r_wdata;
    logic [1:0]  r_idx;         // byte lane currently being transferred
    logic        r_err;
    logic [7:0]  r_cnt;
    logic [31:0] r_rbuf;        // read bytes collected so far for this request
    logic [31:0] r_rdata;
    logic [31:0] r_haddr;
    logic [31:0] r_hwdata;
    logic        r_hwrite;

    logic        w_xfer_end;
    logic        w_ok;
    logic        w_last;
    logic        w_tmo;
    logic        w_abort;
    logic [8:0]  w_cnt_inc;
    logic [1:0]  w_idx_nxt;
    logic [31:0] w_rbuf_nxt;
    logic        w_unused_hrdata;

    // RAM bytes are spread over the FIC window with address bit 1 forced to
    // zero: byte b sits at {BASE_HI, b[14:1], 0, b[0]}.
    function automatic logic [31:0] f_haddr(input logic [14:0] b);
        return {BASE_HI, b[14:1], 1'b0, b[0]};
    endfunction

    assign w_xfer_end = (r_state == S_DATA) && HREADY;
    assign w_ok       = w_xfer_end && !HRESP;
    assign w_last     = !r_size || (r_idx == 2'd3);
    assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
    // w_cnt_inc counts the current DATA cycle, so DATA lasts at most TIMEOUT cycles.
    assign w_tmo      = (r_state == S_DATA) && !HREADY && (w_cnt_inc >= {1'b0, TIMEOUT});
    assign w_abort    = (w_xfer_end && HRESP) || w_tmo;
    assign w_idx_nxt  = r_idx + 2'd1;
    assign w_unused_hrdata = ^HRDATA[31:8];

    // Merge the byte arriving this cycle so rdata is already complete in DONE.
    always_comb begin
        w_rbuf_nxt = r_rbuf;
        if (w_ok && !r_we) begin
            w_rbuf_nxt[{r_idx, 3'b000} +: 8] = HRDATA[7:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req) w_state_nxt = S_ADDR;
            S_ADDR: w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_abort || (w_ok && w_last)) begin
                    w_state_nxt = S_DONE;
                end else if (w_ok) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_size      <= 1'b0;
            r_word_base <= '0;
            r_wdata     <= '0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_rbuf      <= '0;
            r_rdata     <= '0;
            r_haddr     <= '0;
            r_hwdata    <= '0;
            r_hwrite    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we        <= we;
                        r_size      <= size;
                        r_word_base <= addr[14:2];
                        r_wdata     <= wdata;
                        r_idx       <= 2'd0;
                        r_err       <= 1'b0;
                        r_rbuf      <= '0;
                        r_hwrite    <= we;
                        r_haddr     <= f_haddr(size ? {addr[14:2], 2'b00} : addr);
                    end
                end
                S_ADDR: begin
                    r_cnt    <= '0;
                    r_hwdata <= {4{r_wdata[{r_idx, 3'b000} +: 8]}};
                end
                S_DATA: begin
                    r_rbuf <= w_rbuf_nxt;
                    if (w_abort) begin
                        r_err <= 1'b1;
                    end else if (!HREADY) begin
                        r_cnt <= w_cnt_inc[7:0];
                    end
                    if (w_ok && !w_last) begin
                        r_idx   <= w_idx_nxt;
                        r_haddr <= f_haddr({r_word_base, w_idx_nxt});
                    end
                    // rdata reflects read requests only; write acks leave it untouched.
                    if ((w_abort || (w_ok && w_last)) && !r_we) begin
                        r_rdata <= w_rbuf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HTRANS    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
    assign HADDR     = r_haddr;
    assign HWRITE    = r_hwrite;
    assign HWDATA    = r_hwdata;
    assign HSIZE     = 2'b00;
    assign HMASTLOCK = 1'b0;
    assign ack       = (r_state == S_DONE);
    assign err       = (r_state == S_DONE) && r_err;
    assign busy      = (r_state != S_IDLE);
    assign rdata     = r_rdata;

endmodule
